// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 host transmit types, error codes and frame builder
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      DATA,
      ACK,
      WAIT_IDLE
   } state_t;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_START = 2'd1;
   localparam logic [1:0] ERR_XFER  = 2'd2;
   localparam logic [1:0] ERR_NACK  = 2'd3;

   localparam int FRAME_BITS = 11;
   localparam int TIMER_W    = 21;

   // {stop, odd parity, data, start}; shifted out LSB first
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
      return {1'b1, ~^data, data, 1'b0};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-FF synchronizer, debounce and falling-edge detect for one PS/2 line
module ps2_line_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pad,
   output logic level,
   output logic fall
);

   localparam int CNT_W = $clog2(FILTER_LEN) + 1;

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= 2'b11;
         cnt    <= '0;
         level  <= 1'b1;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], pad};
         fall   <= 1'b0;
         if (sync_q[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
            // level flips only after FILTER_LEN consecutive differing samples
            level <= sync_q[1];
            fall  <= level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command transmitter with open-drain pull-low enables
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int START_TIMEOUT  = 1500000,
   parameter int XFER_TIMEOUT   = 200000,
   parameter int FILTER_LEN     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       rx_inhibit,
   output logic       tx_done,
   output logic       tx_err,
   output logic [1:0] err_code
);
   import ps2_pkg::*;

   localparam logic [TIMER_W-1:0] INH_LAST  = TIMER_W'(INHIBIT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] START_LIM = TIMER_W'(START_TIMEOUT);
   localparam logic [TIMER_W-1:0] XFER_LIM  = TIMER_W'(XFER_TIMEOUT);

   state_t                  state, state_n;
   logic [FRAME_BITS-1:0]   shift, shift_n;
   logic [3:0]              bit_cnt, bit_cnt_n;
   logic [TIMER_W-1:0]      timer, timer_n, timer_inc;
   logic [1:0]              err_n;
   logic                    done_n, err_p_n;
   logic                    clk_level, clk_fall, data_level, data_fall_unused;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk(clk), .rst(rst), .pad(ps2_clk_i), .level(clk_level), .fall(clk_fall)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
      .clk(clk), .rst(rst), .pad(ps2_data_i), .level(data_level), .fall(data_fall_unused)
   );

   assign timer_inc  = (&timer) ? timer : timer + 1'b1;
   assign tx_ready   = (state == IDLE);
   assign rx_inhibit = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         shift    <= '1;
         bit_cnt  <= '0;
         timer    <= '0;
         err_code <= ERR_NONE;
         tx_done  <= 1'b0;
         tx_err   <= 1'b0;
      end else begin
         state    <= state_n;
         shift    <= shift_n;
         bit_cnt  <= bit_cnt_n;
         timer    <= timer_n;
         err_code <= err_n;
         tx_done  <= done_n;
         tx_err   <= err_p_n;
      end
   end

   // A device event in the same cycle as a timeout always takes priority.
   always_comb begin
      state_n     = state;
      shift_n     = shift;
      bit_cnt_n   = bit_cnt;
      timer_n     = timer_inc;
      err_n       = err_code;
      done_n      = 1'b0;
      err_p_n     = 1'b0;
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      case (state)
         IDLE: begin
            timer_n = '0;
            if (tx_valid) begin
               shift_n   = build_frame(tx_data);
               bit_cnt_n = '0;
               err_n     = ERR_NONE;
               state_n   = INHIBIT;
            end
         end
         INHIBIT: begin
            ps2_clk_oe = 1'b1;
            if (timer == INH_LAST) begin
               ps2_data_oe = 1'b1;
               timer_n     = '0;
               state_n     = REQ;
            end
         end
         REQ: begin
            ps2_data_oe = ~shift[0];
            if (clk_fall) begin
               shift_n   = {1'b1, shift[FRAME_BITS-1:1]};
               bit_cnt_n = 4'd1;
               timer_n   = '0;
               state_n   = DATA;
            end else if (timer == START_LIM) begin
               err_n   = ERR_START;
               err_p_n = 1'b1;
               state_n = IDLE;
            end
         end
         DATA: begin
            ps2_data_oe = ~shift[0];
            if (clk_fall) begin
               shift_n   = {1'b1, shift[FRAME_BITS-1:1]};
               bit_cnt_n = bit_cnt + 4'd1;
               if (bit_cnt == 4'd9) state_n = ACK;
            end else if (timer == XFER_LIM) begin
               err_n   = ERR_XFER;
               err_p_n = 1'b1;
               state_n = IDLE;
            end
         end
         ACK: begin
            ps2_data_oe = ~shift[0];
            if (clk_fall) begin
               if (!data_level) begin
                  state_n = WAIT_IDLE;
               end else begin
                  err_n   = ERR_NACK;
                  err_p_n = 1'b1;
                  state_n = IDLE;
               end
            end else if (timer == XFER_LIM) begin
               err_n   = ERR_XFER;
               err_p_n = 1'b1;
               state_n = IDLE;
            end
         end
         WAIT_IDLE: begin
            if (clk_level && data_level) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end else if (timer == XFER_LIM) begin
               err_n   = ERR_XFER;
               err_p_n = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
